// File: rtl/hazard_forward_unit.sv
// Shadows in-flight destinations to drive EX operand forwarding selects and load-use stalls.
// Selects registered, 1 cycle from ID; stall is combinational and holds PC and IF/ID for one cycle.
module hazard_forward_unit #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_reg_write,
  input  logic                  id_is_load,
  input  logic                  flush,
  output logic                  stall,
  output logic [1:0]            fwd_a_sel,
  output logic [1:0]            fwd_b_sel,
  output logic [CNT_W-1:0]      stall_count
);

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic                  wr;
    logic                  load;
  } ex_stage_t;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic                  wr;
  } dst_stage_t;

  // The WB slot never feeds a select, so only EX and MEM are shadowed.
  ex_stage_t  ex_q, ex_d;
  dst_stage_t mem_q;

  logic       ex_live, mem_live;
  logic       ex_hit_rs1, ex_hit_rs2;
  logic       bubble;
  logic [1:0] sel_a_d, sel_b_d;

  assign ex_live    = ex_q.wr && (ex_q.rd != '0);
  assign mem_live   = mem_q.wr && (mem_q.rd != '0);
  assign ex_hit_rs1 = id_uses_rs1 && ex_live && (id_rs1 == ex_q.rd);
  assign ex_hit_rs2 = id_uses_rs2 && ex_live && (id_rs2 == ex_q.rd);

  assign stall  = id_valid && !flush && ex_q.load && (ex_hit_rs1 || ex_hit_rs2);
  assign bubble = stall || flush || !id_valid;

  always_comb begin
    ex_d    = '0;
    sel_a_d = 2'b00;
    sel_b_d = 2'b00;
    if (!bubble) begin
      ex_d.rd   = id_rd;
      ex_d.wr   = id_reg_write;
      ex_d.load = id_is_load;
      // The younger producer (now in EX, next in MEM) takes priority.
      if (ex_hit_rs1)
        sel_a_d = 2'b01;
      else if (id_uses_rs1 && mem_live && (id_rs1 == mem_q.rd))
        sel_a_d = 2'b10;
      if (ex_hit_rs2)
        sel_b_d = 2'b01;
      else if (id_uses_rs2 && mem_live && (id_rs2 == mem_q.rd))
        sel_b_d = 2'b10;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q      <= '0;
      mem_q     <= '0;
      fwd_a_sel <= 2'b00;
      fwd_b_sel <= 2'b00;
    end else begin
      ex_q      <= ex_d;
      mem_q.rd  <= ex_q.rd;
      mem_q.wr  <= ex_q.wr;
      fwd_a_sel <= sel_a_d;
      fwd_b_sel <= sel_b_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_count <= '0;
    else if (stall && (stall_count != '1))
      stall_count <= stall_count + CNT_W'(1);
  end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Scoreboard bench: directed instruction stream, expected per-cycle outputs queued by the driver.
module tb_hazard_forward_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        id_valid = 1'b0;
  logic [4:0]  id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic        id_uses_rs1 = 1'b0, id_uses_rs2 = 1'b0;
  logic        id_reg_write = 1'b0, id_is_load = 1'b0, flush = 1'b0;
  logic        stall, stall2;
  logic [1:0]  fa, fb, fa2, fb2;
  logic [15:0] cnt;
  logic [1:0]  cnt2;

  int checks = 0;
  int fails  = 0;
  int row    = 0;

  typedef struct {
    logic       st;
    logic [1:0] a;
    logic [1:0] b;
    int         cnt;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  hazard_forward_unit #(.REG_ADDR_W(5), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_is_load(id_is_load), .flush(flush),
    .stall(stall), .fwd_a_sel(fa), .fwd_b_sel(fb), .stall_count(cnt)
  );

  hazard_forward_unit #(.REG_ADDR_W(5), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_is_load(id_is_load), .flush(flush),
    .stall(stall2), .fwd_a_sel(fa2), .fwd_b_sel(fb2), .stall_count(cnt2)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every cycle with a queued expectation is compared on the falling edge.
  always @(negedge clk) begin
    if (sb.size() != 0) begin
      mon_e = sb.pop_front();
      chk($sformatf("row%0d stall", row), int'(stall), int'(mon_e.st));
      chk($sformatf("row%0d fwd_a_sel", row), int'(fa), int'(mon_e.a));
      chk($sformatf("row%0d fwd_b_sel", row), int'(fb), int'(mon_e.b));
      chk($sformatf("row%0d stall_count", row), int'(cnt), mon_e.cnt);
      chk($sformatf("row%0d stall_w2", row), int'(stall2), int'(mon_e.st));
      chk($sformatf("row%0d fwd_a_w2", row), int'(fa2), int'(mon_e.a));
      chk($sformatf("row%0d fwd_b_w2", row), int'(fb2), int'(mon_e.b));
      chk($sformatf("row%0d stall_count_w2", row), int'(cnt2), (mon_e.cnt > 3) ? 3 : mon_e.cnt);
      row++;
    end
  end

  task automatic step(input logic v, input int rs1, input int rs2, input logic u1, input logic u2,
                      input int rd, input logic rw, input logic ld, input logic fl,
                      input logic es, input logic [1:0] ea, input logic [1:0] eb, input int ec);
    exp_t e;
    @(posedge clk);
    #1;
    id_valid = v; id_rs1 = 5'(rs1); id_rs2 = 5'(rs2);
    id_uses_rs1 = u1; id_uses_rs2 = u2; id_rd = 5'(rd);
    id_reg_write = rw; id_is_load = ld; flush = fl;
    e.st = es; e.a = ea; e.b = eb; e.cnt = ec;
    sb.push_back(e);
  endtask

  task automatic alu(input int rd, input int rs1, input int rs2, input logic fl, input logic es,
                     input logic [1:0] ea, input logic [1:0] eb, input int ec);
    step(1'b1, rs1, rs2, 1'b1, 1'b1, rd, 1'b1, 1'b0, fl, es, ea, eb, ec);
  endtask

  task automatic nop(input logic [1:0] ea, input logic [1:0] eb, input int ec);
    step(1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, ea, eb, ec);
  endtask

  task automatic lw(input int rd, input int rs1, input logic [1:0] ea, input logic [1:0] eb, input int ec);
    step(1'b1, rs1, 0, 1'b1, 1'b0, rd, 1'b1, 1'b1, 1'b0, 1'b0, ea, eb, ec);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    chk("reset stall", int'(stall), 0);
    chk("reset fwd_a_sel", int'(fa), 0);
    chk("reset fwd_b_sel", int'(fb), 0);
    chk("reset stall_count", int'(cnt), 0);
    #10 rst = 1'b0;

    // back-to-back ALU, distance 2, MEM-over-WB priority
    alu(5, 1, 2, 0, 0, 2'b00, 2'b00, 0);
    alu(6, 5, 7, 0, 0, 2'b00, 2'b00, 0);
    nop(2'b01, 2'b00, 0);
    alu(5, 1, 2, 0, 0, 2'b00, 2'b00, 0);
    nop(2'b00, 2'b00, 0);
    alu(8, 9, 5, 0, 0, 2'b00, 2'b00, 0);
    alu(5, 1, 2, 0, 0, 2'b00, 2'b10, 0);
    alu(5, 1, 2, 0, 0, 2'b00, 2'b00, 0);
    alu(10, 5, 5, 0, 0, 2'b00, 2'b00, 0);
    nop(2'b01, 2'b01, 0);
    // load-use: one stall cycle, consumer picks up the load at WB
    lw(3, 2, 2'b00, 2'b00, 0);
    alu(4, 3, 3, 0, 1, 2'b00, 2'b00, 0);
    alu(4, 3, 3, 0, 0, 2'b00, 2'b00, 1);
    nop(2'b10, 2'b10, 1);
    // x0 destination and unused source
    alu(0, 1, 2, 0, 0, 2'b00, 2'b00, 1);
    alu(7, 0, 0, 0, 0, 2'b00, 2'b00, 1);
    lw(3, 2, 2'b00, 2'b00, 1);
    step(1'b1, 6, 3, 1'b1, 1'b0, 9, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1);
    // flush beats a load-use stall
    lw(3, 2, 2'b00, 2'b00, 1);
    alu(4, 3, 3, 1, 0, 2'b00, 2'b00, 1);
    alu(11, 3, 3, 0, 0, 2'b00, 2'b00, 1);
    nop(2'b10, 2'b10, 1);
    // four more stalls: 5 total, narrow counter saturates at 3
    for (int k = 0; k < 4; k++) begin
      lw(3, 2, (k == 0) ? 2'b00 : 2'b10, (k == 0) ? 2'b00 : 2'b10, 1 + k);
      alu(4, 3, 3, 0, 1, 2'b00, 2'b00, 1 + k);
      alu(4, 3, 3, 0, 0, 2'b00, 2'b00, 2 + k);
    end
    nop(2'b10, 2'b10, 5);

    // asynchronous reset in the middle of a stall cycle
    lw(3, 2, 2'b00, 2'b00, 5);
    alu(4, 3, 3, 0, 1, 2'b00, 2'b00, 5);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("async reset stall", int'(stall), 0);
    chk("async reset fwd_a_sel", int'(fa), 0);
    chk("async reset fwd_b_sel", int'(fb), 0);
    chk("async reset stall_count", int'(cnt), 0);
    chk("async reset stall_count_w2", int'(cnt2), 0);
    #1 rst = 1'b0;
    #1;
    chk("post reset stall", int'(stall), 0);

    id_valid = 1'b0;
    flush = 1'b0;
    repeat (2) @(posedge clk);
    chk("scoreboard drained", sb.size(), 0);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/hazard_forward_unit.md
# hazard_forward_unit

Tracks destination registers of in-flight instructions in the 5-stage RISC-V pipeline and produces the 2-bit select codes that drive the EX-stage 3-input 32-bit operand muxes (code 00 = register-file value, 01 = MEM-stage result, 10 = WB-stage result). It also detects load-use hazards, requests a one-cycle stall with bubble insertion, honours branch flushes and keeps a saturating stall counter. It sits between the decode stage and the EX operand muxes.

## Interface
- `REG_ADDR_W`, 5: register index width.
- `CNT_W`, 16: stall counter width.

- `clk`  in  1  pipeline clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `id_valid`  in  1  ID holds a real instruction.
- `id_rs1`, `id_rs2`  in  REG_ADDR_W  source registers of the ID instruction.
- `id_uses_rs1`, `id_uses_rs2`  in  1  source actually read.
- `id_rd`  in  REG_ADDR_W  destination of the ID instruction.
- `id_reg_write`  in  1  ID instruction writes rd.
- `id_is_load`  in  1  ID instruction is a load.
- `flush`  in  1  taken branch resolved in EX; kill the ID instruction.
- `stall`  out  1  hold PC and IF/ID; combinational.
- `fwd_a_sel`, `fwd_b_sel`  out  2  registered selects for the EX rs1/rs2 operand muxes.
- `stall_count`  out  CNT_W  saturating count of stall cycles.

## Operation
- Internal shadow stages: EX {rd, wr, load}, MEM {rd, wr}, WB {rd, wr}. Each advances every clock.
- A destination counts as live only if wr=1 and rd!=0.
- Load-use: `stall`=1 iff `id_valid` & !`flush` & EX.load & EX live & ((`id_uses_rs1` & `id_rs1`==EX.rd) | (`id_uses_rs2` & `id_rs2`==EX.rd)).
- On each edge, EX loads:
  - a bubble (wr=0, load=0, rd=0) when `stall`, `flush` or !`id_valid`;
  - otherwise {`id_rd`, `id_reg_write`, `id_is_load`}.
- MEM and WB always take the previous EX and MEM contents. A stall never freezes them.
- Forward select, computed per operand when the instruction enters EX:
  - 01 if the source is used, old EX is live, and rs==old EX.rd (that instruction becomes MEM);
  - else 10 if old MEM is live and rs==old MEM.rd (that instruction becomes WB);
  - else 00.
- MEM beats WB when both match. Register x0 always yields 00. A bubble entering EX gets 00/00.
- Code 11 is never produced.
- A load never appears at 01. The stall bubble guarantees a load's consumer sees it only at WB (10).
- `stall_count` increments on each edge where `stall`=1, saturating at 2^CNT_W−1.

## Timing
- Reset, asynchronous: all shadow stages become bubbles. `fwd_a_sel`=`fwd_b_sel`=00, `stall_count`=0, so `stall`=0.
- Reset deasserted mid-stall: the stall drops immediately because EX is a bubble.
- `stall` is combinational from ID inputs and registered EX state, valid in the same cycle.
- Selects are registered and valid during the cycle the instruction occupies EX, with latency 1 from ID.
- Stall sequence: edge 0 inserts a bubble into EX while ID holds. At the next ID evaluation the load is in MEM, so `stall`=0 and the consumer enters EX with select 10.
- `flush` and a stall condition in the same cycle: the flush wins. `stall`=0, a bubble is inserted and the counter does not increment.
- The same rd at both MEM and WB: select 01 (youngest).

## Test plan
- Reset: assert `rst` asynchronously mid-cycle → `stall`=0, selects 00, `stall_count`=0 without waiting for a clock edge.
- ALU back-to-back: `add x5` followed by `sub x6,x5,x7` → the sub's EX cycle shows `fwd_a_sel`=01, `fwd_b_sel`=00.
- Distance 2 and priority:
  - `add x5`, nop, `or x8,x9,x5` → `fwd_b_sel`=10.
  - `add x5`, `add x5`, then a use of x5 → 01.
- Load-use: `lw x3`, then `add x4,x3,x3` → `stall`=1 for exactly one cycle and `stall_count`=1. The add then enters EX with `fwd_a_sel`=`fwd_b_sel`=10.
- x0 and unused sources:
  - A write to x0 followed by a read of x0 → 00, no stall.
  - A load to x3 followed by an instruction with `id_uses_rs2`=0 and `id_rs2`=3 → no stall.
- Flush and saturation:
  - `flush` together with a load-use condition → `stall`=0 and a bubble is inserted.
  - With CNT_W=2, 5 stalls → `stall_count`=3.
